// File: rtl/ffo_pkg.sv
// Shared types for the sequential find-first-one scanner: FSM state encoding
// and a width helper that never returns zero for single-bit ranges.
package ffo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_e;

   // Bits needed to address `width` items, floored at 1 so ports stay legal.
   function automatic int posWidth(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/ffo_window.sv
// Combinational STEP-bit priority encoder; bit 0 of the window is the lowest
// position, and the lowest set position wins.
module ffo_window
   import ffo_pkg::*;
#(
   parameter int STEP = 4,
   localparam int IDXW = posWidth(STEP)
) (
   input  logic [STEP-1:0] win_i,
   output logic            hit_o,
   output logic [IDXW-1:0] idx_o
);

   // Walk from the highest position down so the last match is the lowest one.
   always_comb begin
      hit_o = |win_i;
      idx_o = '0;
      for (int i = STEP - 1; i >= 0; i--) begin
         if (win_i[i]) begin
            idx_o = IDXW'(i);
         end
      end
   end

endmodule

// File: rtl/ffo_scan.sv
// Sequential find-first-one engine walking a WIDTH-bit vector STEP bits per cycle.
// Define FFO_SCAN_NEXT_EN to build the HOLD state and `next` iteration.
module ffo_scan
   import ffo_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STEP  = 4,
   localparam int PW   = posWidth(WIDTH),
   localparam int IW   = posWidth(STEP)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             next,
   input  logic [WIDTH-1:0] b,
   output logic [PW-1:0]    p,
   output logic             found,
   output logic             done,
   output logic             ready
);

   state_e           stateQ, stateD;
   logic [WIDTH-1:0] vQ, vD;
   logic [PW-1:0]    wQ, wD;
   logic [PW-1:0]    pQ, pD;
   logic             foundQ, foundD;
   logic             doneQ, doneD;

   logic [WIDTH-1:0] bRev;
   logic [STEP-1:0]  winBits;
   logic             winHit;
   logic [IW-1:0]    winIdx;
   logic [PW-1:0]    hitPos;
   logic             lastWin;

   // V is stored position-indexed so that V[pos] is the bit at that scan position.
   always_comb begin
      bRev = '0;
      for (int i = 0; i < WIDTH; i++) begin
         bRev[i] = b[WIDTH-1-i];
      end
   end

   assign winBits = vQ[wQ +: STEP];
   assign hitPos  = wQ + PW'(winIdx);
   assign lastWin = (int'(wQ) + STEP) >= WIDTH;

   ffo_window #(
      .STEP(STEP)
   ) uWindow (
      .win_i(winBits),
      .hit_o(winHit),
      .idx_o(winIdx)
   );

`ifndef FFO_SCAN_NEXT_EN
   logic unusedNext;
   assign unusedNext = next;
`endif

   always_comb begin
      stateD = stateQ;
      vD     = vQ;
      wD     = wQ;
      pD     = pQ;
      foundD = foundQ;
      doneD  = 1'b0;
      case (stateQ)
         IDLE: begin
            if (start) begin
               vD     = bRev;
               wD     = '0;
               stateD = SCAN;
            end
         end
         SCAN: begin
            if (winHit) begin
               pD     = hitPos;
               foundD = 1'b1;
               doneD  = 1'b1;
`ifdef FFO_SCAN_NEXT_EN
               stateD = HOLD;
`else
               stateD = IDLE;
`endif
            end else if (lastWin) begin
               pD     = '0;
               foundD = 1'b0;
               doneD  = 1'b1;
               stateD = IDLE;
            end else begin
               wD = wQ + PW'(STEP);
            end
         end
`ifdef FFO_SCAN_NEXT_EN
         // Restart beats resume; resume drops the reported bit and rescans its window.
         HOLD: begin
            if (start) begin
               vD     = bRev;
               wD     = '0;
               stateD = SCAN;
            end else if (next) begin
               vD[pQ] = 1'b0;
               stateD = SCAN;
            end
         end
`endif
         default: begin
            stateD = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stateQ <= IDLE;
         vQ     <= '0;
         wQ     <= '0;
         pQ     <= '0;
         foundQ <= 1'b0;
         doneQ  <= 1'b0;
      end else begin
         stateQ <= stateD;
         vQ     <= vD;
         wQ     <= wD;
         pQ     <= pD;
         foundQ <= foundD;
         doneQ  <= doneD;
      end
   end

   assign p     = pQ;
   assign found = foundQ;
   assign done  = doneQ;
   assign ready = (stateQ == IDLE) || (stateQ == HOLD);

endmodule

// File: tb/tb_ffo_scan.sv
// Directed bench for ffo_scan at WIDTH=32 with STEP in {1,2,4,8,32}; the
// FFO_SCAN_NEXT_EN macro selects between iteration checks and single-shot checks.
module tb_ffo_scan;

   localparam int NU = 5;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        startA [NU];
   logic        nextA  [NU];
   logic [31:0] bA     [NU];
   logic [4:0]  pA     [NU];
   logic        foundA [NU];
   logic        doneA  [NU];
   logic        readyA [NU];

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   // One DUT per step size, indexed 0..4 for STEP 1, 2, 4, 8, 32.
   for (genvar g = 0; g < NU; g++) begin : gDut
      localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : (g == 3) ? 8 : 32;
      ffo_scan #(
         .WIDTH(32),
         .STEP(S)
      ) dut (
         .clock(clock),
         .reset(reset),
         .start(startA[g]),
         .next(nextA[g]),
         .b(bA[g]),
         .p(pA[g]),
         .found(foundA[g]),
         .done(doneA[g]),
         .ready(readyA[g])
      );
   end

   function automatic int stepOf(input int u);
      return (u == 0) ? 1 : (u == 1) ? 2 : (u == 2) ? 4 : (u == 3) ? 8 : 32;
   endfunction

   // Reference position of the first set bit counted from the MSB; 32 when none.
   function automatic int refLz(input logic [31:0] v);
      for (int i = 0; i < 32; i++) begin
         if (v[31-i]) return i;
      end
      return 32;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse start/next for one cycle, then count cycles from the accepting edge to done.
   task automatic applyStimulus(input string tag, input int u, input bit doStart, input bit doNext,
                                input logic [31:0] vec, input int expP, input bit expF,
                                input int expLat);
      int cyc;
      bit seen;
      @(negedge clock);
      startA[u] = doStart;
      nextA[u]  = doNext;
      bA[u]     = vec;
      @(negedge clock);
      startA[u] = 1'b0;
      nextA[u]  = 1'b0;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 100) begin
         @(negedge clock);
         cyc++;
         if (doneA[u]) seen = 1'b1;
      end
      checkOutput({tag, " done"}, 32'(seen), 32'd1);
      checkOutput({tag, " latency"}, 32'(cyc), 32'(expLat));
      checkOutput({tag, " p"}, 32'(pA[u]), 32'(expP));
      checkOutput({tag, " found"}, 32'(foundA[u]), 32'(expF));
      checkOutput({tag, " ready"}, 32'(readyA[u]), 32'd1);
   endtask

   initial begin
      int cyc;
      int doneSeen;
      int u;
      int lz;
      logic [31:0] vec;

      for (int i = 0; i < NU; i++) begin
         startA[i] = 1'b0;
         nextA[i]  = 1'b0;
         bA[i]     = '0;
      end

      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      for (int i = 0; i < NU; i++) begin
         checkOutput("reset p", 32'(pA[i]), 32'd0);
         checkOutput("reset found", 32'(foundA[i]), 32'd0);
         checkOutput("reset done", 32'(doneA[i]), 32'd0);
         checkOutput("reset ready", 32'(readyA[i]), 32'd1);
      end

      applyStimulus("s4 pos8", 2, 1'b1, 1'b0, 32'h0080_0000, 8, 1'b1, 3);

      applyStimulus("s4 zero", 2, 1'b1, 1'b0, 32'h0000_0000, 0, 1'b0, 8);
      @(negedge clock);
      checkOutput("s4 zero ready after", 32'(readyA[2]), 32'd1);
      checkOutput("s4 zero done once", 32'(doneA[2]), 32'd0);

      applyStimulus("s32 zero", 4, 1'b1, 1'b0, 32'h0000_0000, 0, 1'b0, 1);

      // Start during SCAN must not reload b: result stays position 31 at 8 cycles.
      @(negedge clock);
      startA[2] = 1'b1;
      bA[2]     = 32'h0000_0001;
      @(negedge clock);
      startA[2] = 1'b0;
      cyc = 0;
      doneSeen = 0;
      while (doneSeen == 0 && cyc < 100) begin
         @(negedge clock);
         cyc++;
         startA[2] = (cyc == 1);
         bA[2]     = (cyc == 1) ? 32'h8000_0000 : 32'h0000_0001;
         if (doneA[2]) doneSeen = 1;
      end
      startA[2] = 1'b0;
      checkOutput("scan start ignored latency", 32'(cyc), 32'd8);
      checkOutput("scan start ignored p", 32'(pA[2]), 32'd31);
      checkOutput("scan start ignored found", 32'(foundA[2]), 32'd1);

      // Reset two cycles into a scan abandons it silently.
      @(negedge clock);
      startA[2] = 1'b1;
      bA[2]     = 32'h0000_0001;
      @(negedge clock);
      startA[2] = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      doneSeen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (doneA[2]) doneSeen++;
      end
      checkOutput("mid-scan reset no done", 32'(doneSeen), 32'd0);
      checkOutput("mid-scan reset p", 32'(pA[2]), 32'd0);
      checkOutput("mid-scan reset found", 32'(foundA[2]), 32'd0);
      checkOutput("mid-scan reset ready", 32'(readyA[2]), 32'd1);

`ifdef FFO_SCAN_NEXT_EN
      applyStimulus("next first", 2, 1'b1, 1'b0, 32'h8000_0001, 0, 1'b1, 1);
      applyStimulus("next second", 2, 1'b0, 1'b1, 32'h0, 31, 1'b1, 8);
      applyStimulus("next exhausted", 2, 1'b0, 1'b1, 32'h0, 0, 1'b0, 1);

      applyStimulus("s8 first", 3, 1'b1, 1'b0, 32'hC000_0000, 0, 1'b1, 1);
      applyStimulus("s8 same window", 3, 1'b0, 1'b1, 32'h0, 1, 1'b1, 1);
      applyStimulus("s8 start beats next", 3, 1'b1, 1'b1, 32'h0000_0100, 23, 1'b1, 3);
`else
      applyStimulus("single hit", 2, 1'b1, 1'b0, 32'h4000_0000, 1, 1'b1, 1);
      @(negedge clock);
      nextA[2] = 1'b1;
      @(negedge clock);
      nextA[2] = 1'b0;
      doneSeen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (doneA[2]) doneSeen++;
      end
      checkOutput("next ignored no done", 32'(doneSeen), 32'd0);
      checkOutput("next ignored p", 32'(pA[2]), 32'd1);
      checkOutput("next ignored ready", 32'(readyA[2]), 32'd1);
`endif

      // Step sweep against the leading-zero reference with shifted random vectors.
      for (int k = 0; k < 4; k++) begin
         u = (k == 3) ? 4 : k;
         for (int r = 0; r < 3; r++) begin
            vec = $urandom() >> $urandom_range(0, 31);
            lz  = refLz(vec);
            applyStimulus($sformatf("sweep step%0d b=%h", stepOf(u), vec), u, 1'b1, 1'b0, vec,
                          (lz < 32) ? lz : 0, lz < 32,
                          (lz < 32) ? (lz / stepOf(u) + 1) : (32 / stepOf(u)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ffo_scan.md
# ffo_scan

Parametrised sequential find-first-one engine. It scans a WIDTH-bit vector STEP bits per clock, MSB-first, and reports the position of the first set bit. With `FFO_SCAN_NEXT_EN` defined it also iterates over every subsequent set bit on request. It is the generalised successor of the 32-bit, one-bit-per-cycle FFO, and sits wherever a bitmap (request mask, free-list, interrupt pending vector) must be walked without a wide combinational priority encoder.

## Interface
Parameters:
- WIDTH, 32, vector width in bits; must be a multiple of STEP, ≥ 2.
- STEP, 4, bits examined per cycle; power of two, 1 ≤ STEP ≤ WIDTH.

Ports:
- clock  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  accept new vector `b`; honoured only while `ready`=1.
- next  in  1  resume search after current hit; honoured only in HOLD (NEXT_EN builds only).
- b  in  WIDTH  input vector; position 0 = b[WIDTH-1], position WIDTH-1 = b[0].
- p  out  $clog2(WIDTH)  position of the reported set bit; 0 when `found`=0.
- found  out  1  1 = `p` is valid; 0 = no (further) set bit exists.
- done  out  1  single-cycle pulse marking a new `p`/`found` result.
- ready  out  1  high in IDLE and HOLD; decoded from state.

## Operation
- Internal regs: V (WIDTH, working copy of b, position-indexed), W (window base, multiple of STEP), state.
- States: IDLE, SCAN, HOLD. HOLD exists only with `FFO_SCAN_NEXT_EN`.
- IDLE: `start`=1 → V←b, W←0, state→SCAN. `next` is ignored.
- SCAN: each cycle, examine V[W .. W+STEP-1]:
  - Hit: p←W+index of the lowest-position set bit in the window, found←1, done←1. state→HOLD (NEXT_EN) or IDLE.
  - Miss, W+STEP<WIDTH: W←W+STEP, stay in SCAN.
  - Miss, last window: p←0, found←0, done←1, state→IDLE.
- HOLD: `start`=1 restarts exactly as from IDLE. `start` has priority over `next`. Otherwise `next`=1 clears V[p], keeps W, and goes to SCAN. The rescan begins in the same window.
- `p`/`found` hold their last values until the next `done`. `done` is 0 in every other cycle.
- `start` asserted during SCAN is ignored; `b` is sampled only on an accepted start.
- Position arithmetic is unsigned $clog2(WIDTH) bits and never wraps, because W+index ≤ WIDTH-1.

## Timing
- Reset: state→IDLE; p=0, found=0, done=0. `ready`=1 from the first cycle after the reset edge.
- Reset mid-SCAN or in HOLD: scan is abandoned, no `done` is issued, and outputs return to reset values.
- Latency from the accepting start edge to the `done` edge:
  - hit at position k: floor(k/STEP)+1 cycles;
  - no hit: WIDTH/STEP cycles.
- `next` latency: floor(k'/STEP) − floor(p/STEP) + 1 cycles to the next `done`, where k' is the next set position.
- Back-to-back: `start` may be asserted in the cycle `done` is high if the state has returned to IDLE/HOLD. Throughput is one result per scan.
- b all zeros with STEP=WIDTH: `done` arrives 1 cycle after start with found=0.

## Configuration
- `FFO_SCAN_NEXT_EN` defined: HOLD state and `next` iteration are built; after a hit, `ready` stays high in HOLD.
- Not defined: no HOLD state and no V bit-clear logic. After any `done` the state is IDLE. The `next` port still exists but is ignored. Behaviour matches a single-shot FFO.

## Structure
- Package `ffo_pkg`: state enum type (IDLE, SCAN, HOLD) and a position-width helper function/localparam (clog2 of WIDTH).
- Sub-module `ffo_window`: combinational STEP-bit priority encoder. It takes the window bits (position order) and outputs hit (1 bit) and index ($clog2(STEP) bits, 0 when STEP=1).
- `ffo_scan` holds the FSM, the V/W registers and the output registers.

## Test plan
- WIDTH=32, STEP=4, b=32'h0080_0000 (position 8): done 3 cycles after start; p=8, found=1.
- WIDTH=32, STEP=4, b=0: done 8 cycles after start; found=0, p=0; ready high the following cycle.
- NEXT_EN, b=32'h8000_0001: first done p=0. `next` → done after 8 cycles with p=31. `next` → done with found=0.
- NEXT_EN, b=32'hC000_0000, STEP=8: p=0, then `next` → p=1 one cycle later (same window). Also `start`+`next` together in HOLD → restart wins and the new b is loaded.
- Reset asserted 2 cycles into a scan of b=32'h0000_0001: no done pulse; p=0, found=0, ready=1 after reset.
- Sweep STEP ∈ {1,2,4,32} with a random b: p equals the reference leading-zero count, and latency matches floor(k/STEP)+1.
